// File: rtl/vga_sync_decoder.sv
// Receive-side VGA sync decoder: recovers pixel coordinates and tile address
// from HS/VS/DA, measures line/frame timing, and reports lock or timing errors.
module vga_sync_decoder #(
    parameter int WIDTH       = 640,
    parameter int HEIGHT      = 480,
    parameter int HTOTAL      = 801,
    parameter int VTOTAL      = 526,
    parameter int HPULSEN     = 1,
    parameter int VPULSEN     = 1,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vga_HS,
    input  logic        vga_VS,
    input  logic        vga_DA,
    output logic        pvalid,
    output logic [9:0]  px,
    output logic [9:0]  py,
    output logic [31:0] vaddr,
    output logic [9:0]  line_len,
    output logic [9:0]  frame_lines,
    output logic        locked,
    output logic        err
);
    localparam logic [31:0] HPOL     = HPULSEN;
    localparam logic [31:0] VPOL     = VPULSEN;
    localparam logic [9:0]  WIDTH_L  = 10'(WIDTH);
    localparam logic [9:0]  HEIGHT_L = 10'(HEIGHT);
    localparam logic [9:0]  HTOTAL_L = 10'(HTOTAL);
    localparam logic [9:0]  VTOTAL_L = 10'(VTOTAL);
    localparam logic [3:0]  LF       = 4'(LOCK_FRAMES);

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    // Stage s1 holds the polarity-normalised syncs, so a cleared history
    // reads as "inactive" and reset release never fakes a sync edge.
    logic s1_hs_reg, s1_vs_reg, s1_da_reg;
    logic s2_hs_reg, s2_vs_reg, s2_da_reg;

    logic        pvalid_reg, pvalid_next;
    logic [9:0]  px_reg, px_next, py_reg, py_next;
    logic [31:0] vaddr_reg, vaddr_next;
    logic [9:0]  hcount_reg, hcount_next, line_len_reg, line_len_next;
    logic [9:0]  vcount_reg, vcount_next, frame_lines_reg, frame_lines_next;
    logic [9:0]  run_reg, run_next, runs_reg, runs_next;
    logic        bad_reg, bad_next, armed_reg, armed_next;
    logic [3:0]  good_reg, good_next;
    logic        locked_reg, locked_next, err_reg, err_next;

    logic        hs_rise, vs_rise, da_rise, da_fall, bad_eff;
    logic [9:0]  hs_len, vcount_eff, runs_eff;
    logic [3:0]  good_inc;

    assign hs_rise = s1_hs_reg & ~s2_hs_reg;
    assign vs_rise = s1_vs_reg & ~s2_vs_reg;
    assign da_rise = s1_da_reg & ~s2_da_reg;
    assign da_fall = ~s1_da_reg & s2_da_reg;

    always_comb begin
        px_next          = px_reg;
        py_next          = py_reg;
        vaddr_next       = vaddr_reg;
        pvalid_next      = s1_da_reg;
        hcount_next      = sat_inc(hcount_reg);
        line_len_next    = line_len_reg;
        frame_lines_next = frame_lines_reg;
        run_next         = run_reg;
        armed_next       = armed_reg;
        good_next        = good_reg;
        locked_next      = locked_reg;
        err_next         = 1'b0;

        if (da_rise)
            px_next = 10'd0;
        else if (s1_da_reg)
            px_next = px_reg + 10'd1;

        if (vs_rise)
            py_next = 10'd0;
        else if (da_fall)
            py_next = sat_inc(py_reg);

        if (s1_da_reg)
            vaddr_next = {27'd0, px_next[9:5]} + {27'd0, py_next[9:5]} * 32'd20;

        hs_len = sat_inc(hcount_reg);
        if (hs_rise) begin
            line_len_next = hs_len;
            hcount_next   = 10'd0;
        end

        if (da_rise)
            run_next = 10'd1;
        else if (s1_da_reg)
            run_next = sat_inc(run_reg);

        // Same-cycle HS edge and DA fall belong to the frame that is ending.
        vcount_eff  = hs_rise ? sat_inc(vcount_reg) : vcount_reg;
        runs_eff    = da_fall ? sat_inc(runs_reg) : runs_reg;
        bad_eff     = bad_reg | (hs_rise & (hs_len != HTOTAL_L))
                              | (da_fall & (run_reg != WIDTH_L));
        vcount_next = vcount_eff;
        runs_next   = runs_eff;
        bad_next    = bad_eff;
        good_inc    = (good_reg >= LF) ? LF : good_reg + 4'd1;

        if (vs_rise) begin
            frame_lines_next = vcount_eff;
            vcount_next      = 10'd0;
            runs_next        = 10'd0;
            bad_next         = 1'b0;
            if (!armed_reg) begin
                armed_next = 1'b1;
            end else if (bad_eff || (runs_eff != HEIGHT_L) || (vcount_eff != VTOTAL_L)) begin
                err_next    = 1'b1;
                locked_next = 1'b0;
                good_next   = 4'd0;
            end else begin
                good_next = good_inc;
                if (good_inc == LF)
                    locked_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_hs_reg       <= 1'b0;
            s1_vs_reg       <= 1'b0;
            s1_da_reg       <= 1'b0;
            s2_hs_reg       <= 1'b0;
            s2_vs_reg       <= 1'b0;
            s2_da_reg       <= 1'b0;
            pvalid_reg      <= 1'b0;
            px_reg          <= 10'd0;
            py_reg          <= 10'd0;
            vaddr_reg       <= 32'd0;
            hcount_reg      <= 10'd0;
            line_len_reg    <= 10'd0;
            vcount_reg      <= 10'd0;
            frame_lines_reg <= 10'd0;
            run_reg         <= 10'd0;
            runs_reg        <= 10'd0;
            bad_reg         <= 1'b0;
            armed_reg       <= 1'b0;
            good_reg        <= 4'd0;
            locked_reg      <= 1'b0;
            err_reg         <= 1'b0;
        end else begin
            s1_hs_reg       <= vga_HS ^ HPOL[0];
            s1_vs_reg       <= vga_VS ^ VPOL[0];
            s1_da_reg       <= vga_DA;
            s2_hs_reg       <= s1_hs_reg;
            s2_vs_reg       <= s1_vs_reg;
            s2_da_reg       <= s1_da_reg;
            pvalid_reg      <= pvalid_next;
            px_reg          <= px_next;
            py_reg          <= py_next;
            vaddr_reg       <= vaddr_next;
            hcount_reg      <= hcount_next;
            line_len_reg    <= line_len_next;
            vcount_reg      <= vcount_next;
            frame_lines_reg <= frame_lines_next;
            run_reg         <= run_next;
            runs_reg        <= runs_next;
            bad_reg         <= bad_next;
            armed_reg       <= armed_next;
            good_reg        <= good_next;
            locked_reg      <= locked_next;
            err_reg         <= err_next;
        end
    end

    assign pvalid      = pvalid_reg;
    assign px          = px_reg;
    assign py          = py_reg;
    assign vaddr       = vaddr_reg;
    assign line_len    = line_len_reg;
    assign frame_lines = frame_lines_reg;
    assign locked      = locked_reg;
    assign err         = err_reg;
endmodule
